// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with row synchroniser, press/release debounce and hex key output.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner #(
    parameter int unsigned SCAN_CYCLES     = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 20000,
    parameter int unsigned REPEAT_CYCLES   = 500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key_value,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned DwellW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int unsigned DebW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned RepW   = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

    localparam logic [DwellW-1:0] DwellLast = DwellW'(SCAN_CYCLES - 1);
    localparam logic [DebW-1:0]   DebLast   = DebW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RepW-1:0]   RepLast   = RepW'(REPEAT_CYCLES - 1);

`ifdef KEYPAD_REPEAT_EN
    localparam bit RepeatEn = 1'b1;
`else
    localparam bit RepeatEn = 1'b0;
`endif

    typedef enum logic [1:0] {
        StScan,
        StDebounce,
        StHeld,
        StRelease
    } state_e;

    state_e            state_q;
    logic [3:0]        rows_m;
    logic [3:0]        rows_s;
    logic [1:0]        col_idx;
    logic [1:0]        row_q;
    logic [DwellW-1:0] dwell_cnt;
    logic [DebW-1:0]   deb_cnt;
    logic [RepW-1:0]   rep_cnt;

    logic       row_low;
    logic       any_low;
    logic [1:0] low_row;
    logic [3:0] key_code;

    assign cols    = ~(4'b0001 << col_idx);
    assign row_low = ~rows_s[row_q];
    assign any_low = ~&rows_s;

    // Lowest-index active row wins when several rows are low together.
    always_comb begin
        low_row = 2'd3;
        if (!rows_s[0]) begin
            low_row = 2'd0;
        end else if (!rows_s[1]) begin
            low_row = 2'd1;
        end else if (!rows_s[2]) begin
            low_row = 2'd2;
        end
    end

    always_comb begin
        key_code = 4'h0;
        unique case ({row_q, col_idx})
            4'b00_00: key_code = 4'h1;
            4'b00_01: key_code = 4'h2;
            4'b00_10: key_code = 4'h3;
            4'b00_11: key_code = 4'hA;
            4'b01_00: key_code = 4'h4;
            4'b01_01: key_code = 4'h5;
            4'b01_10: key_code = 4'h6;
            4'b01_11: key_code = 4'hB;
            4'b10_00: key_code = 4'h7;
            4'b10_01: key_code = 4'h8;
            4'b10_10: key_code = 4'h9;
            4'b10_11: key_code = 4'hC;
            4'b11_00: key_code = 4'hE;
            4'b11_01: key_code = 4'h0;
            4'b11_10: key_code = 4'hF;
            4'b11_11: key_code = 4'hD;
            default:  key_code = 4'h0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StScan;
            rows_m    <= 4'hF;
            rows_s    <= 4'hF;
            col_idx   <= 2'd0;
            row_q     <= 2'd0;
            dwell_cnt <= '0;
            deb_cnt   <= '0;
            rep_cnt   <= '0;
            key_value <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            rows_m    <= rows;
            rows_s    <= rows_m;
            key_valid <= 1'b0;
            case (state_q)
                StScan: begin
                    if (dwell_cnt == DwellLast) begin
                        dwell_cnt <= '0;
                        if (any_low) begin
                            row_q   <= low_row;
                            deb_cnt <= '0;
                            state_q <= StDebounce;
                        end else begin
                            col_idx <= col_idx + 2'd1;
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt + 1'b1;
                    end
                end
                StDebounce: begin
                    if (!row_low) begin
                        deb_cnt   <= '0;
                        dwell_cnt <= '0;
                        col_idx   <= col_idx + 2'd1;
                        state_q   <= StScan;
                    end else if (deb_cnt == DebLast) begin
                        key_value <= key_code;
                        key_valid <= 1'b1;
                        key_held  <= 1'b1;
                        rep_cnt   <= '0;
                        state_q   <= StHeld;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                StHeld: begin
                    if (!row_low) begin
                        deb_cnt <= '0;
                        rep_cnt <= '0;
                        state_q <= StRelease;
                    end else if (RepeatEn) begin
                        if (rep_cnt == RepLast) begin
                            rep_cnt   <= '0;
                            key_valid <= 1'b1;
                        end else begin
                            rep_cnt <= rep_cnt + 1'b1;
                        end
                    end
                end
                StRelease: begin
                    if (row_low) begin
                        deb_cnt <= '0;
                        rep_cnt <= '0;
                        state_q <= StHeld;
                    end else if (deb_cnt == DebLast) begin
                        deb_cnt   <= '0;
                        dwell_cnt <= '0;
                        key_held  <= 1'b0;
                        col_idx   <= col_idx + 2'd1;
                        state_q   <= StScan;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                default: state_q <= StScan;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner; key matrix modelled from the driven columns.
module tb_keypad_scanner;

    logic       clk;
    logic       reset;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] key_value;
    logic       key_valid;
    logic       key_held;

    logic [3:0] pressed [4];  // pressed[row] = column mask of keys held down

    int checks  = 0;
    int errors  = 0;
    int strobes = 0;
    logic prev_valid = 1'b0;
    logic [3:0] exp_q [$];

    keypad_scanner #(
        .SCAN_CYCLES    (4),
        .DEBOUNCE_CYCLES(8),
        .REPEAT_CYCLES  (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rows     (rows),
        .cols     (cols),
        .key_value(key_value),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int r = 0; r < 4; r++) begin
            rows[r] = ~|(pressed[r] & ~cols);
        end
    end

    // Strobe monitor: every key_valid pops the next expected code.
    always @(negedge clk) begin
        if (reset) begin
            prev_valid = 1'b0;
        end else begin
            if (key_valid) begin
                strobes++;
                if (prev_valid) begin
                    checks++;
                    errors++;
                    $display("FAIL valid_back_to_back: key_valid high two cycles, required single");
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe: key_value=%h, required no strobe", key_value);
                end else begin
                    logic [3:0] exp;
                    exp = exp_q.pop_front();
                    if (key_value !== exp) begin
                        errors++;
                        $display("FAIL strobe_value: got %h, required %h", key_value, exp);
                    end
                end
            end
            prev_valid = key_valid;
        end
    end

    task automatic release_all();
        for (int r = 0; r < 4; r++) pressed[r] = 4'h0;
    endtask

    task automatic wait_held(input logic level, input int budget, input string name);
        int n;
        n = 0;
        while (key_held !== level && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (key_held !== level) begin
            errors++;
            $display("FAIL %s: key_held=%b after %0d cycles, required %b", name, key_held, budget,
                     level);
        end
    endtask

    task automatic wait_cols(input logic [3:0] target, input int budget, input string name);
        int n;
        n = 0;
        while (cols !== target && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (cols !== target) begin
            errors++;
            $display("FAIL %s: cols=%b after %0d cycles, required %b", name, cols, budget, target);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        release_all();
        repeat (3) @(negedge clk);
        checks += 4;
        if (cols !== 4'b1110) begin
            errors++;
            $display("FAIL reset_cols: got %b, required 1110", cols);
        end
        if (key_value !== 4'h0) begin
            errors++;
            $display("FAIL reset_value: got %h, required 0", key_value);
        end
        if (key_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b, required 0", key_valid);
        end
        if (key_held !== 1'b0) begin
            errors++;
            $display("FAIL reset_held: got %b, required 0", key_held);
        end
        reset = 1'b0;
    endtask

    task automatic test_reset_mid_debounce();
        int s0;
        pressed[1] = 4'b0010;
        wait_cols(4'b1101, 40, "mid_reset_reach_col1");
        repeat (7) @(negedge clk);
        reset = 1'b1;
        #1;
        checks += 3;
        if (cols !== 4'b1110) begin
            errors++;
            $display("FAIL mid_reset_cols: got %b, required 1110", cols);
        end
        if (key_held !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_held: got %b, required 0", key_held);
        end
        if (key_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_valid: got %b, required 0", key_valid);
        end
        release_all();
        @(negedge clk);
        reset = 1'b0;
        s0 = strobes;
        repeat (30) @(negedge clk);
        checks += 2;
        if (strobes != s0) begin
            errors++;
            $display("FAIL mid_reset_no_strobe: %0d strobes, required 0", strobes - s0);
        end
        if (key_value !== 4'h0) begin
            errors++;
            $display("FAIL mid_reset_value: got %h, required 0", key_value);
        end
    endtask

    task automatic test_single_press();
        int s0;
        s0 = strobes;
        exp_q.push_back(4'h6);
        pressed[1] = 4'b0100;
        wait_held(1'b1, 80, "single_accept");
        repeat (40) @(negedge clk);
        release_all();
        repeat (4) @(negedge clk);
        checks++;
        if (key_held !== 1'b1) begin
            errors++;
            $display("FAIL single_held_during_release: got %b, required 1", key_held);
        end
        wait_held(1'b0, 30, "single_release");
        checks += 2;
        if (cols !== 4'b0111) begin
            errors++;
            $display("FAIL single_resume_col: got %b, required 0111", cols);
        end
        if (strobes - s0 != 1) begin
            errors++;
            $display("FAIL single_strobe_count: got %0d, required 1", strobes - s0);
        end
    endtask

    task automatic test_bounce();
        int s0;
        logic [3:0] kv;
        s0 = strobes;
        kv = key_value;
        wait_cols(4'b1101, 40, "bounce_reach_col1");
        pressed[2] = 4'b0010;
        repeat (6) @(negedge clk);
        release_all();
        repeat (10) @(negedge clk);
        checks += 3;
        if (strobes != s0) begin
            errors++;
            $display("FAIL bounce_no_strobe: got %0d, required 0", strobes - s0);
        end
        if (key_value !== kv) begin
            errors++;
            $display("FAIL bounce_value: got %h, required %h", key_value, kv);
        end
        if (key_held !== 1'b0) begin
            errors++;
            $display("FAIL bounce_held: got %b, required 0", key_held);
        end
        wait_cols(4'b1011, 40, "bounce_scan_resumes");
    endtask

    task automatic test_two_rows();
        int s0;
        s0 = strobes;
        exp_q.push_back(4'h1);
        pressed[0] = 4'b0001;
        pressed[2] = 4'b0001;
        wait_held(1'b1, 80, "two_rows_accept");
        repeat (10) @(negedge clk);
        release_all();
        wait_held(1'b0, 40, "two_rows_release");
        checks++;
        if (strobes - s0 != 1) begin
            errors++;
            $display("FAIL two_rows_strobe_count: got %0d, required 1", strobes - s0);
        end
    endtask

    task automatic test_no_rollover();
        int s0;
        s0 = strobes;
        exp_q.push_back(4'hA);
        pressed[0] = 4'b1000;
        wait_held(1'b1, 80, "rollover_accept_a");
        pressed[3] = 4'b0010;
        repeat (20) @(negedge clk);
        checks++;
        if (strobes - s0 != 1) begin
            errors++;
            $display("FAIL rollover_ignored: got %0d strobes, required 1", strobes - s0);
        end
        exp_q.push_back(4'h0);
        pressed[0] = 4'b0000;
        wait_held(1'b0, 40, "rollover_release_a");
        wait_held(1'b1, 80, "rollover_accept_0");
        repeat (5) @(negedge clk);
        release_all();
        wait_held(1'b0, 40, "rollover_release_0");
        checks++;
        if (strobes - s0 != 2) begin
            errors++;
            $display("FAIL rollover_strobe_count: got %0d, required 2", strobes - s0);
        end
    endtask

    task automatic test_repeat();
        int s0;
        int n;
        int nexp;
`ifdef KEYPAD_REPEAT_EN
        nexp = 4;
`else
        nexp = 1;
`endif
        s0 = strobes;
        for (int i = 0; i < nexp; i++) exp_q.push_back(4'hF);
        pressed[3] = 4'b0100;
        n = 0;
        while (key_valid !== 1'b1 && n < 80) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (key_valid !== 1'b1) begin
            errors++;
            $display("FAIL repeat_accept: key_valid=%b after 80 cycles, required 1", key_valid);
        end
        repeat (60) @(negedge clk);
        release_all();
        wait_held(1'b0, 40, "repeat_release");
        checks++;
        if (strobes - s0 != nexp) begin
            errors++;
            $display("FAIL repeat_strobe_count: got %0d, required %0d", strobes - s0, nexp);
        end
    endtask

    initial begin
        release_all();
        reset = 1'b1;
        test_reset();
        test_reset_mid_debounce();
        test_single_press();
        test_bounce();
        test_two_rows();
        test_no_rollover();
        test_repeat();
        repeat (10) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expected strobes missing, required 0",
                     exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
